fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 102 ++++++++++
 tb/tb_fifo_rd_stream.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-port drainer: pops into a 3-entry skid buffer
// and presents the data as a valid/ready stream with burst framing.
module fifo_rd_stream #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              rclk,
  input  logic              rstn,
  input  logic              en,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rempty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [15:0]       beat_cnt,
  output logic              busy
);

  localparam int IDX_W =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(BURST_LEN - 1);

  logic [DATA_W-1:0] r_mem [3];
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [IDX_W-1:0]  r_beat_idx;
  logic [15:0]       r_beat_cnt;

  logic              w_pop;
  logic              w_cap;
  logic              w_xfer;
  logic [2:0]        w_credit;

  function automatic logic [1:0] f_next(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the in-flight pop, so m_ready never reaches fifo_ren.
  assign w_credit = {1'b0, r_occ}
                  + {2'b00, r_inflight};
  assign fifo_ren = rstn & en & ~fifo_rempty
                  & (w_credit < 3'd3);
  assign w_pop    = fifo_ren;
  assign w_cap    = r_inflight;

  assign m_valid  = (r_occ != 2'd0);
  assign w_xfer   = m_valid & m_ready;
  assign m_data   = m_valid ? r_mem[r_rd_ptr]
                            : '0;
  assign m_last   = m_valid
                  & (r_beat_idx == IDX_MAX);
  assign beat_cnt = r_beat_cnt;
  assign busy     = m_valid | r_inflight;

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= 2'd0;
    end else if (w_cap) begin
      r_mem[r_wr_ptr] <= fifo_rdata;
      r_wr_ptr        <= f_next(r_wr_ptr);
    end
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_pop;
      unique case (1'b1)
        (w_cap & ~w_xfer): r_occ <= r_occ + 2'd1;
        (~w_cap & w_xfer): r_occ <= r_occ - 2'd1;
        default:           r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr   <= 2'd0;
      r_beat_idx <= '0;
      r_beat_cnt <= 16'd0;
    end else if (w_xfer) begin
      r_rd_ptr   <= f_next(r_rd_ptr);
      r_beat_cnt <= r_beat_cnt + 16'd1;
      if (r_beat_idx == IDX_MAX)
        r_beat_idx <= '0;
      else
        r_beat_idx <= r_beat_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_fifo_rd_stream;

  localparam int BL = 4;

  logic        rclk = 1'b0;
  logic        rstn;
  logic        en;
  logic        fifo_ren;
  logic [15:0] fifo_rdata;
  logic        fifo_rempty;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic [15:0] beat_cnt;
  logic        busy;

  fifo_rd_stream #(
    .DATA_W    (16),
    .BURST_LEN (BL)
  ) dut (
    .rclk        (rclk),
    .rstn        (rstn),
    .en          (en),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .beat_cnt    (beat_cnt),
    .busy        (busy)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        ren;
    logic        vld;
    logic [15:0] dat;
    logic        lst;
    logic        bsy;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  logic [15:0] src[$];
  logic [15:0] exp_q[$];
  int          outst;
  int          lpop;
  int          nxf;
  int          npop;
  logic        pend;
  logic [15:0] pend_v;
  logic        hold;
  logic [15:0] hold_d;
  logic [15:0] last_data;

  logic        s_ren;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic [15:0] s_cnt;
  logic        s_busy;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic vec_t mk(
    input int e, input int r, input int f,
    input int v, input int d, input int l,
    input int b
  );
    vec_t t;
    t.en  = 1'(e);
    t.rdy = 1'(r);
    t.ren = 1'(f);
    t.vld = 1'(v);
    t.dat = 16'(d);
    t.lst = 1'(l);
    t.bsy = 1'(b);
    return t;
  endfunction

  task automatic model_clear();
    outst = 0;
    lpop  = 0;
    nxf   = 0;
    exp_q.delete();
    pend  = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic load_seq(input int n);
    for (int i = 1; i <= n; i++)
      src.push_back(16'(i));
  endtask

  // Called at posedge+1; checks the asynchronous clear without an edge.
  task automatic do_reset();
    fifo_rempty = (src.size() == 0);
    rstn = 1'b0;
    #2;
    chk("rst_ren",   32'(fifo_ren), 32'd0);
    chk("rst_valid", 32'(m_valid),  32'd0);
    chk("rst_last",  32'(m_last),   32'd0);
    chk("rst_data",  32'(m_data),   32'd0);
    chk("rst_cnt",   32'(beat_cnt), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    @(posedge rclk);
    #1;
    rstn = 1'b1;
    model_clear();
  endtask

  // Outstanding = popped but not yet transferred = occ + inflight.
  task automatic cyc(
    input logic ien,
    input logic irdy,
    input logic iforce
  );
    logic        pop;
    logic        xf;
    logic        rexp;
    logic        vexp;
    logic        lexp;
    logic [15:0] hd;
    en          = ien;
    m_ready     = irdy;
    fifo_rempty = iforce || (src.size() == 0);
    fifo_rdata  = pend ? pend_v : 16'($urandom);
    #4;
    s_ren   = fifo_ren;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_cnt   = beat_cnt;
    s_busy  = busy;
    rexp = ien && !fifo_rempty && (outst < 3);
    vexp = (outst - lpop) > 0;
    lexp = vexp && ((nxf % BL) == BL - 1);
    chk("fifo_ren", 32'(s_ren),   32'(rexp));
    chk("m_valid",  32'(s_valid), 32'(vexp));
    chk("m_last",   32'(s_last),  32'(lexp));
    chk("busy",     32'(s_busy),  32'(outst != 0));
    chk("beat_cnt", 32'(s_cnt),   32'(16'(nxf)));
    if (hold) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data",  32'(s_data),  32'(hold_d));
    end
    pop = s_ren && !fifo_rempty;
    xf  = s_valid && irdy;
    if (xf) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL m_data: spurious beat %0h at %0t",
                 s_data, $time);
      end else begin
        hd = exp_q.pop_front();
        if (s_data === hd) n_pass++;
        else $display("FAIL m_data: got %0h want %0h at %0t",
                      s_data, hd, $time);
      end
      last_data = s_data;
    end
    hold   = s_valid && !irdy;
    hold_d = s_data;
    outst  = outst + int'(pop) - int'(xf);
    lpop   = int'(pop);
    nxf    = nxf + int'(xf);
    if (pop) begin
      pend_v = src.pop_front();
      pend   = 1'b1;
      exp_q.push_back(pend_v);
      npop++;
    end else begin
      pend = 1'b0;
    end
    @(posedge rclk);
    #1;
  endtask

  initial begin
    vec_t        tv[15];
    int          base;
    int          p0;
    int          x0;
    logic        got;
    logic [15:0] fd;

    tv[0]  = mk(1, 0, 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 1, 0, 0, 0, 1);
    tv[2]  = mk(1, 0, 1, 1, 1, 0, 1);
    tv[3]  = mk(1, 0, 0, 1, 1, 0, 1);
    tv[4]  = mk(1, 0, 0, 1, 1, 0, 1);
    tv[5]  = mk(1, 0, 0, 1, 1, 0, 1);
    tv[6]  = mk(1, 1, 0, 1, 1, 0, 1);
    tv[7]  = mk(1, 1, 1, 1, 2, 0, 1);
    tv[8]  = mk(1, 1, 1, 1, 3, 0, 1);
    tv[9]  = mk(1, 1, 1, 1, 4, 1, 1);
    tv[10] = mk(1, 1, 1, 1, 5, 0, 1);
    tv[11] = mk(1, 1, 1, 1, 6, 0, 1);
    tv[12] = mk(1, 1, 0, 1, 7, 0, 1);
    tv[13] = mk(1, 1, 0, 1, 8, 1, 1);
    tv[14] = mk(1, 1, 0, 0, 0, 0, 0);

    rstn        = 1'b0;
    en          = 1'b0;
    m_ready     = 1'b0;
    fifo_rempty = 1'b1;
    fifo_rdata  = 16'd0;
    npop        = 0;
    last_data   = 16'd0;
    model_clear();
    @(posedge rclk);
    #1;
    do_reset();

    // empty FIFO with en high: nothing moves
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'($urandom), 1'b0);
    chk("idle_ren",   32'(s_ren),   32'd0);
    chk("idle_valid", 32'(s_valid), 32'd0);
    chk("idle_busy",  32'(s_busy),  32'd0);

    // backpressure then release, vector table
    do_reset();
    load_seq(8);
    for (int i = 0; i < 15; i++) begin
      cyc(tv[i].en, tv[i].rdy, 1'b0);
      chk("tv_ren",   32'(s_ren),   32'(tv[i].ren));
      chk("tv_valid", 32'(s_valid), 32'(tv[i].vld));
      if (tv[i].vld)
        chk("tv_data", 32'(s_data), 32'(tv[i].dat));
      chk("tv_last",  32'(s_last),  32'(tv[i].lst));
      chk("tv_busy",  32'(s_busy),  32'(tv[i].bsy));
    end
    chk("tv_cnt", 32'(s_cnt), 32'd8);

    // full-rate stream of 8 beats
    do_reset();
    load_seq(8);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i == 1)
        chk("lat_c1", 32'(s_valid), 32'd0);
      if (i == 2)
        chk("lat_c2", 32'(s_valid), 32'd1);
    end
    chk("stream_cnt", 32'(s_cnt), 32'd8);

    // en drop after two pops, then resume
    load_seq(8);
    base = nxf;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("en_off_ren", 32'(s_ren), 32'd0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b0);
    chk("en_off_beats", 32'(nxf - base), 32'd2);
    chk("en_off_busy",  32'(s_busy),     32'd0);
    base = nxf;
    got  = 1'b0;
    fd   = 16'd0;
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (!got && nxf > base) begin
        got = 1'b1;
        fd  = last_data;
      end
    end
    chk("resume_first", 32'(fd), 32'd3);

    // rempty toggling every cycle, random m_ready
    for (int i = 0; i < 300; i++)
      src.push_back(16'($urandom));
    p0 = npop;
    x0 = nxf;
    for (int i = 0; i < 500; i++)
      cyc(1'b1, 1'($urandom), 1'(i % 2));
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0);
    chk("toggle_cnt", 32'(nxf - x0), 32'(npop - p0));

    // random en, rempty and m_ready
    p0 = npop;
    x0 = nxf;
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 1'($urandom % 4 != 0),
          1'($urandom % 3 == 0));
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0);
    chk("rand_cnt", 32'(nxf - x0), 32'(npop - p0));

    // reset with occ=2, inflight=1
    src.delete();
    load_seq(8);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst_busy", 32'(s_busy), 32'd1);
    do_reset();
    for (int i = 0; i < 12; i++)
      cyc(1'b1, 1'b1, 1'b0);
    chk("post_rst_cnt", 32'(s_cnt), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
